// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive path: FSM states,
// bit-counter codes and default bit-period settings.
package uart_rx_pkg;

  typedef enum logic {
    UART_STATE_IDLE = 1'b0,
    UART_STATE_RX   = 1'b1
  } uart_state_e;

  // bit_cnt holds 0..7 for data bits, plus two codes for the framing bits
  localparam logic [3:0] UART_BIT_CNT_MSB   = 4'd7;
  localparam logic [3:0] UART_BIT_CNT_START = 4'd8;
  localparam logic [3:0] UART_BIT_CNT_STOP  = 4'd9;

  localparam int UART_DIV_RATE  = 260;
  localparam int UART_DIV_CNT_W = 9;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a "previous" flop
// used to detect the falling edge that marks a start bit.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // All flops reset to the idle-line level so reset release never looks like a start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_s       = rx_sync;
  assign start_edge = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Samples each bit at mid-bit time and
// reports every completed frame with a one-cycle rx_end pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_RATE  = UART_DIV_RATE,
  parameter int DIV_CNT_W = UART_DIV_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam logic [DIV_CNT_W-1:0] DIV_RELOAD = DIV_CNT_W'(DIV_RATE);
  localparam logic [DIV_CNT_W-1:0] DIV_HALF   = DIV_CNT_W'(DIV_RATE >> 1);

  uart_state_e          state;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic [3:0]           bit_cnt;
  logic [7:0]           sh_reg;
  logic                 rx_s;
  logic                 start_edge;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  // rx_busy is the registered FSM state, so it doubles as the state probe
  assign rx_busy = (state == UART_STATE_RX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= UART_STATE_IDLE;
      div_cnt <= DIV_RELOAD;
      bit_cnt <= UART_BIT_CNT_START;
      sh_reg  <= 8'h00;
      rx_end  <= 1'b0;
      rx_data <= 8'h00;
      rx_ferr <= 1'b0;
    end else begin
      rx_end <= 1'b0;
      case (state)
        UART_STATE_IDLE: begin
          // Half-period load puts every later sample at mid-bit
          if (start_edge) begin
            state   <= UART_STATE_RX;
            div_cnt <= DIV_HALF;
            bit_cnt <= UART_BIT_CNT_START;
          end
        end
        UART_STATE_RX: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_RELOAD;
            case (bit_cnt)
              UART_BIT_CNT_START: begin
                if (rx_s == UART_START_BIT) begin
                  bit_cnt <= 4'd0;
                end else begin
                  state <= UART_STATE_IDLE;
                end
              end
              UART_BIT_CNT_MSB: begin
                sh_reg  <= {rx_s, sh_reg[7:1]};
                bit_cnt <= UART_BIT_CNT_STOP;
              end
              UART_BIT_CNT_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught
                rx_data <= sh_reg;
                rx_ferr <= (rx_s != UART_STOP_BIT);
                rx_end  <= 1'b1;
                state   <= UART_STATE_IDLE;
                bit_cnt <= UART_BIT_CNT_START;
              end
              default: begin
                sh_reg  <= {rx_s, sh_reg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
              end
            endcase
          end
        end
        default: state <= UART_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are generated at bit level, the expected
// byte/flag/arrival time is queued, and a monitor checks each rx_end.
module tb_uart_rx;

  localparam int DIV      = 15;
  localparam int BIT_CLKS = DIV + 1;
  localparam int LAT      = 2 + (DIV >> 1) + 9 * (DIV + 1) + 1;
  localparam int TOL      = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       rx_busy;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rx_ferr;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  logic [8:0]  exp_q[$];      // {ferr, data}
  int unsigned exp_cyc_q[$];  // cycle of the start-bit falling edge

  uart_rx #(.DIV_RATE(DIV), .DIV_CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_busy (rx_busy),
    .rx_end  (rx_end),
    .rx_data (rx_data),
    .rx_ferr (rx_ferr)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  logic [8:0]  mon_e;
  int unsigned mon_c;
  int          mon_lat;
  logic        end_d = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      end_d = 1'b0;
    end else begin
      if (rx_end) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_end: got data %0h ferr %0b, expected no frame (cycle %0d)",
                   rx_data, rx_ferr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(mon_e[7:0]));
          check("rx_ferr", 32'(rx_ferr), 32'(mon_e[8]));
          mon_lat = int'(cyc - mon_c);
          checks++;
          if (mon_lat < LAT - TOL || mon_lat > LAT + TOL) begin
            failures++;
            $display("FAIL rx_end_latency: got %0d expected %0d +-%0d", mon_lat, LAT, TOL);
          end
        end
        if (end_d) begin
          checks++;
          failures++;
          $display("FAIL rx_end_width: got pulse longer than 1 cycle, expected 1 (cycle %0d)", cyc);
        end
      end
      end_d = rx_end;
    end
  end

  // driver: caller is aligned to a negedge; task returns aligned to a negedge.
  // abort_bit >= 0 applies reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int low_after, input int abort_bit);
    if (abort_bit < 0) begin
      exp_q.push_back({~stop, d});
      exp_cyc_q.push_back(cyc);
    end
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS / 2) @(negedge clk);
      if (abort_bit == i) begin
        reset = 1'b0;
        #1;
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_end",  32'(rx_end),  32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_ferr", 32'(rx_ferr), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        return;
      end
      check("busy_in_frame", 32'(rx_busy), 32'd1);
      repeat (BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    if (!stop) begin
      repeat (low_after * BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d frames pending, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic glitch(input int low_clks);
    logic [7:0] prev_data;
    logic       seen;
    prev_data = rx_data;
    seen      = 1'b0;
    rx = 1'b0;
    repeat (low_clks) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 32'd1);
    check("glitch_busy_end",  32'(rx_busy), 32'd0);
    check("glitch_data_kept", 32'(rx_data), 32'(prev_data));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_end",  32'(rx_end),  32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(rx_ferr), 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // single good frame
    send_frame(8'h55, 1'b1, 0, -1);
    wait_drain();
    repeat (10) @(negedge clk);

    // back-to-back, no idle gap
    send_frame(8'hA3, 1'b1, 0, -1);
    send_frame(8'h0F, 1'b1, 0, -1);
    wait_drain();
    repeat (10) @(negedge clk);

    // short glitch is a false start
    glitch(3);

    // framing error with line held low, then recovery
    send_frame(8'h81, 1'b0, 2, -1);
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h3C, 1'b1, 0, -1);
    wait_drain();
    repeat (10) @(negedge clk);

    // reset during data bit 4, then recovery
    send_frame(8'hF0, 1'b1, 0, 4);
    send_frame(8'hC3, 1'b1, 0, -1);
    wait_drain();

    // transmitter-style stream of corner bytes
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    send_frame(8'h5A, 1'b1, 0, -1);
    wait_drain();

    // randomized frames, occasional framing errors and idle gaps
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic       stop;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, int'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_drain();
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
